// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
//   Bundles the value-load handshake, blink control and the multiplexed
//   decoder-side outputs of the two-digit credit/price display scanner.
//
//   value_in      7  binary value to display (0..99 valid, larger clamps to 99)
//   value_load    1  single-cycle capture strobe, honoured only while busy=0
//   blink_en      1  level: blank the whole display on alternate blink phases
//   busy          1  conversion in progress
//   overflow      1  last accepted value exceeded 99
//   digit_number  7  decoder code: 0..9, or 10 = blank
//   digit_enable  2  one-hot digit strobe: 2'b01 ones, 2'b10 tens, 2'b00 off
//
//   master: the client that loads values and consumes the scan outputs
//   slave : the scan controller itself
// -----------------------------------------------------------------------------
interface display_scan_controller_if;
  logic [6:0] value_in;
  logic       value_load;
  logic       blink_en;
  logic       busy;
  logic       overflow;
  logic [6:0] digit_number;
  logic [1:0] digit_enable;

  modport master (
    output value_in,
    output value_load,
    output blink_en,
    input  busy,
    input  overflow,
    input  digit_number,
    input  digit_enable
  );

  modport slave (
    input  value_in,
    input  value_load,
    input  blink_en,
    output busy,
    output overflow,
    output digit_number,
    output digit_enable
  );
endinterface

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//   Drives one shared BCD-to-seven-segment decoder for a two-digit display.
//   A loaded binary value (clamped to 99) is split into tens/ones by repeated
//   subtraction of ten, one step per clock; the shown digits change only when
//   the conversion completes, so the display never shows a half-converted
//   value. A free-running refresh counter alternates the decoder between the
//   ones and tens digit; the tens digit is blanked when it is zero. A slow
//   blink phase, derived from the scan slots, can blank the whole display.
//
// Parameters
//   REFRESH_DIV  clocks each digit stays enabled per scan slot (>= 2)
//   BLINK_DIV    scan slots per blink half-period (>= 1)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    display_scan_controller_if.slave (load handshake + scan outputs)
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                        clk,
  input  logic                        rst_n,
  display_scan_controller_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [6:0] MAX_VALUE  = 7'd99;
  localparam logic [6:0] BLANK_CODE = 7'd10;

  // Conversion FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  // Digit select encoding
  localparam logic SEL_ONES = 1'b0;
  localparam logic SEL_TENS = 1'b1;

  localparam logic [1:0] EN_ONES = 2'b01;
  localparam logic [1:0] EN_TENS = 2'b10;
  localparam logic [1:0] EN_OFF  = 2'b00;

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic [6:0] rem;
  logic [3:0] tens_acc;
  logic [3:0] shown_tens;
  logic [3:0] shown_ones;
  logic       busy_r;
  logic       overflow_r;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rem        <= '0;
      tens_acc   <= '0;
      shown_tens <= '0;
      shown_ones <= '0;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.value_load) begin
            rem        <= (bus.value_in > MAX_VALUE) ? MAX_VALUE : bus.value_in;
            tens_acc   <= '0;
            overflow_r <= (bus.value_in > MAX_VALUE);
            busy_r     <= 1'b1;
            state      <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          // Subtract only while rem >= 10, so rem can never wrap below zero.
          if (rem >= 7'd10) begin
            rem      <= rem - 7'd10;
            tens_acc <= tens_acc + 4'd1;
          end else begin
            state <= S_COMMIT;
          end
        end

        S_COMMIT: begin
          // Both digits change on the same edge: no torn tens/ones pair.
          shown_tens <= tens_acc;
          shown_ones <= rem[3:0];
          busy_r     <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan and blink timing
  // ---------------------------------------------------------------------------
  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] slot_cnt;
  logic          digit_sel;
  logic          blink_phase;

  logic          slot_end;
  logic          blink_wrap;
  logic          sel_next;
  logic          phase_next;
  logic [6:0]    number_next;
  logic [1:0]    enable_next;

  // NOTE: every signal driven here receives a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    slot_end    = (refresh_cnt == REFRESH_LAST);
    blink_wrap  = slot_end && (slot_cnt == BLINK_LAST);
    sel_next    = digit_sel ^ slot_end;
    phase_next  = blink_phase ^ blink_wrap;

    number_next = {3'b000, shown_ones};
    enable_next = EN_ONES;
    if (sel_next == SEL_TENS) begin
      number_next = (shown_tens == 4'd0) ? BLANK_CODE : {3'b000, shown_tens};
      enable_next = EN_TENS;
    end

    // Blanking only gates the strobe; the decoder code keeps scanning.
    if (bus.blink_en && phase_next) begin
      enable_next = EN_OFF;
    end
  end

  logic [6:0] digit_number_r;
  logic [1:0] digit_enable_r;

  // Outputs are registered from the next-state select and phase so the
  // strobe, the digit code and slot/blink boundaries all move on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt    <= '0;
      slot_cnt       <= '0;
      digit_sel      <= SEL_ONES;
      blink_phase    <= 1'b0;
      digit_number_r <= '0;
      digit_enable_r <= EN_ONES;
    end else begin
      refresh_cnt <= slot_end ? '0 : refresh_cnt + 1'b1;
      if (slot_end) begin
        slot_cnt <= blink_wrap ? '0 : slot_cnt + 1'b1;
      end
      digit_sel      <= sel_next;
      blink_phase    <= phase_next;
      digit_number_r <= number_next;
      digit_enable_r <= enable_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.busy         = busy_r;
  assign bus.overflow     = overflow_r;
  assign bus.digit_number = digit_number_r;
  assign bus.digit_enable = digit_enable_r;

endmodule
